// File: rtl/md_fu_pipe_pkg.sv
// Shared definitions for the queued multiply/divide functional unit: unit select
// encodings, func_sel op codes, FSM state type, the queued request record and
// the divide special-case helpers used by both the pipe and the divider.
package md_fu_pipe_pkg;

    localparam int unsigned MD_XLEN = 64;
    localparam int unsigned MD_PRA  = 6;
    localparam int unsigned MD_RIW  = 6;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} md_state_e;

    typedef struct packed {
        logic [MD_PRA-1:0]  prd;
        logic [MD_RIW-1:0]  rob;
        logic [MD_XLEN-1:0] oprd1;
        logic [MD_XLEN-1:0] oprd2;
        logic [2:0]         func_sel;
        logic               muldiv;
    } md_req_t;

    // Divide by zero, or signed MIN / -1, at the width chosen by func_sel[2].
    function automatic logic div_special(input logic [MD_XLEN-1:0] a, input logic [MD_XLEN-1:0] b,
                                         input logic [2:0] sel);
        logic sgn;
        logic b_zero;
        logic ovf;
        sgn = !sel[0];
        if (sel[2]) begin
            b_zero = (b[31:0] == 32'h0);
            ovf    = sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        end else begin
            b_zero = (b == '0);
            ovf    = sgn && (a == {1'b1, {(MD_XLEN-1){1'b0}}}) && (b == '1);
        end
        return b_zero || ovf;
    endfunction

    // Result for a request where div_special() is true.
    function automatic logic [MD_XLEN-1:0] div_special_value(input logic [MD_XLEN-1:0] a,
                                                             input logic [MD_XLEN-1:0] b,
                                                             input logic [2:0] sel);
        logic [MD_XLEN-1:0] r;
        logic               b_zero;
        b_zero = sel[2] ? (b[31:0] == 32'h0) : (b == '0);
        if (b_zero) r = sel[1] ? a : '1;
        else        r = sel[1] ? '0 : a;  // overflow: quotient is the dividend (MIN)
        if (sel[2]) r = {{(MD_XLEN-32){r[31]}}, r[31:0]};
        return r;
    endfunction

endpackage

// File: rtl/md_div.sv
// Fixed-latency divider unit (RISC-V DIV/DIVU/REM/REMU and W forms).
// Accepts one request when idle, raises resp_valid_o for one cycle LAT cycles later.
// Ports: clk, rst, req_valid_i/req_ready_o, oprd1_i, oprd2_i, func_sel_i,
// resp_valid_o, resp_value_o.
module md_div
    import md_fu_pipe_pkg::*;
#(
    parameter int unsigned LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [MD_XLEN-1:0] oprd1_i,
    input  logic [MD_XLEN-1:0] oprd2_i,
    input  logic [2:0]         func_sel_i,
    output logic               resp_valid_o,
    output logic [MD_XLEN-1:0] resp_value_o
);
    localparam int unsigned CW = $clog2(LAT + 1);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [MD_XLEN-1:0] a_q, b_q;
    logic [2:0]         sel_q;
    logic [31:0]        w;

    assign req_ready_o  = !busy_q;
    assign resp_valid_o = busy_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (req_valid_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(LAT - 1);
            a_q    <= oprd1_i;
            b_q    <= oprd2_i;
            sel_q  <= func_sel_i;
        end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        w            = '0;
        resp_value_o = '0;
        if (div_special(a_q, b_q, sel_q)) begin
            resp_value_o = div_special_value(a_q, b_q, sel_q);
        end else if (sel_q[2]) begin
            unique case (sel_q[1:0])
                OP_DIV:  w = $signed(a_q[31:0]) / $signed(b_q[31:0]);
                OP_DIVU: w = a_q[31:0] / b_q[31:0];
                OP_REM:  w = $signed(a_q[31:0]) % $signed(b_q[31:0]);
                OP_REMU: w = a_q[31:0] % b_q[31:0];
                default: w = '0;
            endcase
            resp_value_o = {{(MD_XLEN-32){w[31]}}, w};
        end else begin
            unique case (sel_q[1:0])
                OP_DIV:  resp_value_o = $signed(a_q) / $signed(b_q);
                OP_DIVU: resp_value_o = a_q / b_q;
                OP_REM:  resp_value_o = $signed(a_q) % $signed(b_q);
                OP_REMU: resp_value_o = a_q % b_q;
                default: resp_value_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/md_mul.sv
// Fixed-latency multiplier unit. Accepts one request when idle, raises
// resp_valid_o for one cycle LAT cycles later. func_sel[2] selects the
// 32-bit form (low product word, sign-extended).
// Ports: clk, rst, req_valid_i/req_ready_o, oprd1_i, oprd2_i, func_sel_i,
// resp_valid_o, resp_value_o.
module md_mul
    import md_fu_pipe_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [MD_XLEN-1:0] oprd1_i,
    input  logic [MD_XLEN-1:0] oprd2_i,
    input  logic [2:0]         func_sel_i,
    output logic               resp_valid_o,
    output logic [MD_XLEN-1:0] resp_value_o
);
    localparam int unsigned CW = $clog2(LAT + 1);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [MD_XLEN-1:0] a_q, b_q;
    logic [2:0]         sel_q;
    logic               sa, sb;
    logic [2*MD_XLEN-1:0] prod;

    assign req_ready_o  = !busy_q;
    assign resp_valid_o = busy_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (req_valid_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(LAT - 1);
            a_q    <= oprd1_i;
            b_q    <= oprd2_i;
            sel_q  <= func_sel_i;
        end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    // Sign-extend to 2*XLEN; the truncated unsigned product is the exact result.
    always_comb begin
        sa   = (sel_q[1:0] != OP_MULHU);
        sb   = !((sel_q[1:0] == OP_MULHSU) || (sel_q[1:0] == OP_MULHU));
        prod = {{MD_XLEN{sa & a_q[MD_XLEN-1]}}, a_q} * {{MD_XLEN{sb & b_q[MD_XLEN-1]}}, b_q};
        if (sel_q[2])                 resp_value_o = {{(MD_XLEN-32){prod[31]}}, prod[31:0]};
        else if (sel_q[1:0] == OP_MUL) resp_value_o = prod[MD_XLEN-1:0];
        else                          resp_value_o = prod[2*MD_XLEN-1:MD_XLEN];
    end

endmodule

// File: rtl/md_req_fifo.sv
// Synchronous FIFO of md_req_t with a registered head.
// Ports: clk, rst (sync, active-high), clr_i (sync flush), push_i/din_i,
// pop_i, head_o (entry at read pointer), empty_o, full_o, count_o (occupancy).
module md_req_fifo
    import md_fu_pipe_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  md_req_t                   din_i,
    input  logic                      pop_i,
    output md_req_t                   head_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(QDEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(QDEPTH);

    // Extra pointer MSB distinguishes full from empty.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    md_req_t     mem_q [QDEPTH];

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/md_fu_pipe.sv
// Queued multiply/divide functional unit. Requests are buffered in a QDEPTH
// FIFO, issued one at a time to the mul or div unit (divide special cases are
// resolved locally), and each result is held in an output register until
// writeback accepts it.
// Ports: clk, rst (sync, active-high), flush_i; req_* issue side with
// req_ready_o; wrb_* writeback side with wrb_ready_i; busy_o; qcount_o.
module md_fu_pipe
    import md_fu_pipe_pkg::*;
#(
    parameter int unsigned XLEN               = MD_XLEN,
    parameter int unsigned PHY_REG_ADDR_WIDTH = MD_PRA,
    parameter int unsigned ROB_INDEX_WIDTH    = MD_RIW,
    parameter int unsigned QDEPTH             = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] req_prd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    req_rob_index_i,
    input  logic [XLEN-1:0]               req_oprd1_i,
    input  logic [XLEN-1:0]               req_oprd2_i,
    input  logic [2:0]                    req_func_sel_i,
    input  logic                          req_muldiv_i,
    output logic                          wrb_valid_o,
    input  logic                          wrb_ready_i,
    output logic [PHY_REG_ADDR_WIDTH-1:0] wrb_prd_addr_o,
    output logic [ROB_INDEX_WIDTH-1:0]    wrb_rob_index_o,
    output logic [XLEN-1:0]               wrb_data_o,
    output logic                          busy_o,
    output logic [$clog2(QDEPTH):0]       qcount_o
);
    md_state_e state_q;
    md_req_t   in_req, head;
    logic      kill, push, pop, fifo_empty, fifo_full;
    logic      head_valid, head_fast, issue_ok, unit_ready, fast_load;
    logic      sel_q;
    logic      mul_req_valid, mul_ready, mul_resp_valid;
    logic      div_req_valid, div_ready, div_resp_valid;
    logic [XLEN-1:0] mul_resp_value, div_resp_value, head_fast_value;

    assign kill   = rst || flush_i;
    assign in_req = '{prd: req_prd_addr_i, rob: req_rob_index_i, oprd1: req_oprd1_i,
                      oprd2: req_oprd2_i, func_sel: req_func_sel_i, muldiv: req_muldiv_i};

    assign req_ready_o = !fifo_full && !kill;
    assign push        = req_valid_i && req_ready_o;

    md_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush_i),
        .push_i  (push),
        .din_i   (in_req),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (qcount_o)
    );

    assign head_valid      = !fifo_empty;
    assign head_fast       = (head.muldiv == MD_DIV) && div_special(head.oprd1, head.oprd2, head.func_sel);
    assign head_fast_value = div_special_value(head.oprd1, head.oprd2, head.func_sel);

    // Sub-units are only ever requested from IDLE.
    assign issue_ok      = (state_q == IDLE) && head_valid && !head_fast && !kill;
    assign mul_req_valid = issue_ok && (head.muldiv == MD_MUL);
    assign div_req_valid = issue_ok && (head.muldiv == MD_DIV);
    assign unit_ready    = (head.muldiv == MD_DIV) ? div_ready : mul_ready;

    // A fast-path head can also be loaded in the cycle the held result is handed off.
    assign fast_load = head_valid && head_fast && !kill &&
                       ((state_q == IDLE) || ((state_q == HOLD) && wrb_ready_i));
    assign pop       = fast_load || (issue_ok && unit_ready);

    md_mul u_mul (
        .clk          (clk),
        .rst          (kill),
        .req_valid_i  (mul_req_valid),
        .req_ready_o  (mul_ready),
        .oprd1_i      (head.oprd1),
        .oprd2_i      (head.oprd2),
        .func_sel_i   (head.func_sel),
        .resp_valid_o (mul_resp_valid),
        .resp_value_o (mul_resp_value)
    );

    md_div u_div (
        .clk          (clk),
        .rst          (kill),
        .req_valid_i  (div_req_valid),
        .req_ready_o  (div_ready),
        .oprd1_i      (head.oprd1),
        .oprd2_i      (head.oprd2),
        .func_sel_i   (head.func_sel),
        .resp_valid_o (div_resp_valid),
        .resp_value_o (div_resp_value)
    );

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= IDLE;
        end else if (fast_load) begin
            wrb_prd_addr_o  <= head.prd;
            wrb_rob_index_o <= head.rob;
            wrb_data_o      <= head_fast_value;
            state_q         <= HOLD;
        end else begin
            unique case (state_q)
                IDLE: if (issue_ok && unit_ready) begin
                    wrb_prd_addr_o  <= head.prd;
                    wrb_rob_index_o <= head.rob;
                    sel_q           <= head.muldiv;
                    state_q         <= WAIT;
                end
                WAIT: begin
                    if ((sel_q == MD_DIV) ? div_resp_valid : mul_resp_valid) begin
                        wrb_data_o <= (sel_q == MD_DIV) ? div_resp_value : mul_resp_value;
                        state_q    <= HOLD;
                    end
                end
                HOLD: if (wrb_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrb_valid_o = (state_q == HOLD) && !flush_i;
    assign busy_o      = head_valid || (state_q != IDLE);

endmodule

// File: tb/tb_md_fu_pipe.sv
// Self-checking bench for md_fu_pipe: directed corner cases plus randomized
// traffic, all results compared against an arithmetic reference model.
module tb_md_fu_pipe;
    import md_fu_pipe_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o, req_muldiv_i = 1'b0;
    logic [5:0]  req_prd_addr_i = '0, req_rob_index_i = '0;
    logic [63:0] req_oprd1_i = '0, req_oprd2_i = '0;
    logic [2:0]  req_func_sel_i = '0;
    logic        wrb_valid_o, wrb_ready_i = 1'b1, busy_o;
    logic [5:0]  wrb_prd_addr_o, wrb_rob_index_o;
    logic [63:0] wrb_data_o;
    logic [2:0]  qcount_o;

    int n_vec = 0, n_err = 0, div_req_cnt = 0, full_cnt = 0;
    logic full_seen = 1'b0;
    logic [5:0] rob_ctr = '0;

    typedef struct {logic [5:0] prd; logic [5:0] rob; logic [63:0] data;} exp_t;
    exp_t exp_q[$];

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    md_fu_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .req_prd_addr_i(req_prd_addr_i),
        .req_rob_index_i(req_rob_index_i), .req_oprd1_i(req_oprd1_i),
        .req_oprd2_i(req_oprd2_i), .req_func_sel_i(req_func_sel_i),
        .req_muldiv_i(req_muldiv_i), .wrb_valid_o(wrb_valid_o), .wrb_ready_i(wrb_ready_i),
        .wrb_prd_addr_o(wrb_prd_addr_o), .wrb_rob_index_o(wrb_rob_index_o),
        .wrb_data_o(wrb_data_o), .busy_o(busy_o), .qcount_o(qcount_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model straight from the RISC-V M-extension definitions.
    function automatic logic [63:0] ref_calc(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] sel, input logic md);
        logic [127:0] x, y, p;
        logic [31:0]  w, a32, b32;
        logic [63:0]  r;
        logic         z, ovf;
        a32 = a[31:0];
        b32 = b[31:0];
        if (md == MD_MUL) begin
            if (sel[2]) begin
                w = a32 * b32;
                return {{32{w[31]}}, w};
            end
            x = (sel[1:0] == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
            y = (sel[1:0] == 2'b01 || sel[1:0] == 2'b00) ? {{64{b[63]}}, b} : {64'd0, b};
            p = x * y;
            return (sel[1:0] == 2'b00) ? p[63:0] : p[127:64];
        end
        if (sel[2]) begin
            z   = (b32 == 0);
            ovf = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
            case (sel[1:0])
                2'b00: w = z ? 32'hFFFF_FFFF : ovf ? a32 : 32'($signed(a32) / $signed(b32));
                2'b01: w = z ? 32'hFFFF_FFFF : a32 / b32;
                2'b10: w = z ? a32 : ovf ? 32'd0 : 32'($signed(a32) % $signed(b32));
                default: w = z ? a32 : a32 % b32;
            endcase
            return {{32{w[31]}}, w};
        end
        z   = (b == 0);
        ovf = (a == MIN64) && (b == '1);
        case (sel[1:0])
            2'b00: r = z ? '1 : ovf ? a : 64'($signed(a) / $signed(b));
            2'b01: r = z ? '1 : a / b;
            2'b10: r = z ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
            default: r = z ? a : a % b;
        endcase
        return r;
    endfunction

    // Scoreboard: enqueue model results on accept, compare on writeback handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush_i) begin
            exp_q.delete();
        end else begin
            if (wrb_valid_o && wrb_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("wrb_unexpected", {63'd0, wrb_valid_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wrb_data", wrb_data_o, e.data);
                    check("wrb_prd", 64'(wrb_prd_addr_o), 64'(e.prd));
                    check("wrb_rob", 64'(wrb_rob_index_o), 64'(e.rob));
                end
            end
            if (req_valid_i && req_ready_o) begin
                e.prd  = req_prd_addr_i;
                e.rob  = req_rob_index_i;
                e.data = ref_calc(req_oprd1_i, req_oprd2_i, req_func_sel_i, req_muldiv_i);
                exp_q.push_back(e);
            end
            if (req_valid_i && !req_ready_o && !full_seen) begin
                full_seen = 1'b1;
                full_cnt  = int'(qcount_o);
            end
            if (dut.div_req_valid) div_req_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [2:0] sel,
                        input logic md);
        int n = 0;
        req_valid_i = 1'b1;
        req_oprd1_i = a; req_oprd2_i = b; req_func_sel_i = sel; req_muldiv_i = md;
        req_prd_addr_i = 6'($urandom); req_rob_index_i = rob_ctr; rob_ctr++;
        @(negedge clk);
        while (!req_ready_o && n < 300) begin @(negedge clk); n++; end
        if (!req_ready_o) check("push_timeout", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_wrb();
        int n = 0;
        @(negedge clk);
        while (!wrb_valid_o && n < 300) begin @(negedge clk); n++; end
        if (!wrb_valid_o) check("wrb_timeout", {63'd0, wrb_valid_o}, 64'd1);
    endtask

    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] sel, input logic md, input logic [63:0] exp);
        push(a, b, sel, md);
        wait_wrb();
        check(tag, wrb_data_o, exp);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_o || wrb_valid_o) && n < 2000) begin @(negedge clk); n++; end
        check("idle_timeout", {63'd0, busy_o}, 64'd0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] d0;
        logic [5:0]  p0, r0;
        logic        stable;

        repeat (3) @(negedge clk);
        check("rst_ready_low", {63'd0, req_ready_o}, 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_wrb_valid", {63'd0, wrb_valid_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_qcount", 64'(qcount_o), 64'd0);
        check("rst_ready", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk); #1;

        run_one("mul_7x-3", 64'd7, -64'sd3, 3'b000, MD_MUL, 64'hFFFF_FFFF_FFFF_FFEB);

        // DIVW 5/0: fast path, result at accept+2, divider untouched.
        div_req_cnt = 0;
        push(64'd5, 64'd0, 3'b100, MD_DIV);
        @(negedge clk);
        check("fast_lat_n1", {63'd0, wrb_valid_o}, 64'd0);
        @(negedge clk);
        check("fast_lat_n2", {63'd0, wrb_valid_o}, 64'd1);
        check("divw_by0", wrb_data_o, '1);
        @(posedge clk); #1;
        run_one("remu_by0", 64'd9, 64'd0, 3'b011, MD_DIV, 64'd9);
        run_one("div_ovf", MIN64, '1, 3'b000, MD_DIV, MIN64);
        run_one("rem_ovf", MIN64, '1, 3'b010, MD_DIV, 64'd0);
        check("div_req_fast", 64'(div_req_cnt), 64'd0);
        run_one("div_plain", 64'd100, 64'd7, 3'b000, MD_DIV, 64'd14);

        // Fill the queue behind a long divide.
        full_seen = 1'b0;
        for (int i = 0; i < 6; i++) push(64'(1000 + i), 64'd7, 3'b001, MD_DIV);
        check("full_seen", {63'd0, full_seen}, 64'd1);
        check("full_qcount", 64'(full_cnt), 64'd4);
        wait_idle();

        // Writeback backpressure.
        wrb_ready_i = 1'b0;
        push(64'd11, 64'd13, 3'b000, MD_MUL);
        push(64'd5, 64'd5, 3'b000, MD_MUL);
        wait_wrb();
        d0 = wrb_data_o; p0 = wrb_prd_addr_o; r0 = wrb_rob_index_o;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!wrb_valid_o || wrb_data_o !== d0 || wrb_prd_addr_o !== p0 ||
                wrb_rob_index_o !== r0) stable = 1'b0;
        end
        check("hold_stable", {63'd0, stable}, 64'd1);
        check("hold_data", d0, 64'd143);
        @(posedge clk); #1;
        wrb_ready_i = 1'b1;
        wait_idle();

        // Flush with a divide in flight and three queued.
        for (int i = 0; i < 4; i++) push(64'd1000, 64'd3, 3'b000, MD_DIV);
        @(negedge clk);
        check("flush_pre_q", 64'(qcount_o), 64'd3);
        @(posedge clk); #1; flush_i = 1'b1; req_valid_i = 1'b1;
        @(negedge clk);
        check("flush_wrb_mask", {63'd0, wrb_valid_o}, 64'd0);
        check("flush_ready_mask", {63'd0, req_ready_o}, 64'd0);
        @(posedge clk); #1; flush_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        check("flush_qcount", 64'(qcount_o), 64'd0);
        check("flush_busy", {63'd0, busy_o}, 64'd0);
        check("flush_wrb", {63'd0, wrb_valid_o}, 64'd0);
        @(posedge clk); #1;
        run_one("mul_after_flush", 64'd2, 64'd3, 3'b000, MD_MUL, 64'd6);
        wait_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            req_valid_i    = ($urandom_range(0, 2) != 0);
            req_oprd1_i    = rnd_val();
            req_oprd2_i    = rnd_val();
            req_func_sel_i = 3'($urandom);
            req_muldiv_i   = 1'($urandom);
            req_prd_addr_i = 6'($urandom);
            req_rob_index_i = rob_ctr;
            if (req_valid_i && req_ready_o) rob_ctr++;
            wrb_ready_i    = ($urandom_range(0, 3) != 0);
            flush_i        = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0; flush_i = 1'b0; wrb_ready_i = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
